run_sequencer: RTL and testbench

- Upstream controller for the processor core; owns the core's `start` input and consumes its `done` output.
- Runs NUM_PROGS programs back to back. For each: selects a program index, pulses start, then counts cycles until done.
- Flags any program that exceeds a cycle budget. Used by the bench and the FPGA wrapper to drive multi-program runs.

---
 rtl/run_sequencer.sv | 146 ++++++++++++++
 tb/tb_run_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// Back-to-back program runner for the processor core: pulses core_start, times each
// program until a qualified core_done, and flags budget overruns. RUN_SEQUENCER_LOG_EN adds a per-program cycle log.
module run_sequencer #(
  parameter int               NUM_PROGS    = 3,
  parameter int               START_CYCLES = 2,
  parameter int               CYC_W        = 16,
  parameter logic [CYC_W-1:0] TIMEOUT      = 16'd4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             core_done,
  output logic             core_start,
  output logic [1:0]       prog_sel,
  output logic             busy,
  output logic [CYC_W-1:0] cycles,
  output logic             cycles_valid,
  output logic             timeout_err,
  output logic             all_done,
  input  logic [1:0]       log_idx,
  output logic [CYC_W-1:0] log_cycles
);

  localparam int             SW         = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SW-1:0]  START_LAST = SW'(START_CYCLES - 1);
  localparam logic [1:0]     LAST_PROG  = 2'(NUM_PROGS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SW-1:0]      start_cnt;
  logic [CYC_W-1:0]   cyc_cnt;
  logic               armed;
  logic               leave_run;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // The timeout check comes first: at counter == TIMEOUT a simultaneous done no longer counts.
  always_comb begin
    // NOTE: defaults first so every path assigns the signal and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = START;
      START:   if (start_cnt == START_LAST) state_next = RUN;
      RUN: begin
        if (cyc_cnt == TIMEOUT)         state_next = CAPTURE;
        else if (core_done && armed)    state_next = CAPTURE;
      end
      CAPTURE: state_next = (prog_sel == LAST_PROG) ? FINISH : START;
      FINISH:  if (!go) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign leave_run = (state == RUN) && (state_next == CAPTURE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_cnt   <= '0;
      cyc_cnt     <= '0;
      armed       <= 1'b0;
      prog_sel    <= 2'd0;
      cycles      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            prog_sel    <= 2'd0;
            timeout_err <= 1'b0;
            start_cnt   <= '0;
          end
        end
        START: begin
          if (start_cnt == START_LAST) begin
            cyc_cnt <= '0;
            armed   <= 1'b0;
          end else begin
            start_cnt <= start_cnt + SW'(1);
          end
        end
        RUN: begin
          if (leave_run) begin
            cycles <= cyc_cnt;
            if (cyc_cnt == TIMEOUT) timeout_err <= 1'b1;
          end else begin
            // Saturation is implicit: RUN is always left once the counter equals TIMEOUT.
            cyc_cnt <= cyc_cnt + CYC_W'(1);
            if ((cyc_cnt + CYC_W'(1)) == TIMEOUT) timeout_err <= 1'b1;
            if (!core_done) armed <= 1'b1;
          end
        end
        CAPTURE: begin
          if (prog_sel != LAST_PROG) begin
            prog_sel  <= prog_sel + 2'd1;
            start_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_start   = (state == START);
  assign busy         = (state == START) || (state == RUN) || (state == CAPTURE);
  assign cycles_valid = (state == CAPTURE);
  assign all_done     = (state == FINISH);

`ifdef RUN_SEQUENCER_LOG_EN
  logic [CYC_W-1:0] log_mem [NUM_PROGS];

  // NOTE: this small register array is reset like ordinary flops; large RAMs would not be.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PROGS; i++) log_mem[i] <= '0;
    end else if (state == IDLE && go) begin
      for (int i = 0; i < NUM_PROGS; i++) log_mem[i] <= '0;
    end else if (leave_run) begin
      for (int i = 0; i < NUM_PROGS; i++)
        if (prog_sel == 2'(i)) log_mem[i] <= cyc_cnt;
    end
  end

  always_comb begin
    log_cycles = '0;
    for (int i = 0; i < NUM_PROGS; i++)
      if (log_idx == 2'(i)) log_cycles = log_mem[i];
  end
`else
  logic unused_log_idx;
  assign unused_log_idx = ^log_idx;
  assign log_cycles     = '0;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: a core model drives core_done from per-program
// waveforms and a rule-level reference predicts every capture, timeout and log entry.
module tb_run_sequencer;

  localparam int NUM_PROGS    = 3;
  localparam int START_CYCLES = 2;
  localparam int CYC_W        = 16;
  localparam int TIMEOUT      = 4000;
  localparam int NEVER        = 1000000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             go = 1'b0;
  logic             core_done = 1'b0;
  logic             core_start;
  logic [1:0]       prog_sel;
  logic             busy;
  logic [CYC_W-1:0] cycles;
  logic             cycles_valid;
  logic             timeout_err;
  logic             all_done;
  logic [1:0]       log_idx = 2'd0;
  logic [CYC_W-1:0] log_cycles;

  int n_checks = 0;
  int n_errors = 0;

  // Per-program core_done waveform over RUN cycle index i: high for i < wave_h,
  // low for the next wave_l cycles, then high for good.
  int wave_h  [NUM_PROGS];
  int wave_l  [NUM_PROGS];
  int exp_log [NUM_PROGS];

  always #5 clk = ~clk;

  run_sequencer #(
    .NUM_PROGS   (NUM_PROGS),
    .START_CYCLES(START_CYCLES),
    .CYC_W       (CYC_W),
    .TIMEOUT     (16'(TIMEOUT))
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .core_done   (core_done),
    .core_start  (core_start),
    .prog_sel    (prog_sel),
    .busy        (busy),
    .cycles      (cycles),
    .cycles_valid(cycles_valid),
    .timeout_err (timeout_err),
    .all_done    (all_done),
    .log_idx     (log_idx),
    .log_cycles  (log_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit done_level(input int p, input int i);
    return (i < wave_h[p]) || (i >= wave_h[p] + wave_l[p]);
  endfunction

  // A done counts only after a low has been seen in an earlier RUN cycle; the budget
  // expires at index TIMEOUT, which wins over a done seen in that same cycle.
  task automatic ref_capture(input int p, output int c, output bit err);
    bit seen_low = 1'b0;
    c   = TIMEOUT;
    err = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (done_level(p, i) && seen_low) begin
        c   = i;
        err = 1'b0;
        break;
      end
      if (!done_level(p, i)) seen_low = 1'b1;
    end
  endtask

  task automatic set_wave(input int p, input int h, input int l);
    wave_h[p] = h;
    wave_l[p] = l;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_all_done"}, all_done, 0);
    check({tag, "_valid"}, cycles_valid, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic check_log();
    int exp;
    for (int k = 0; k < 4; k++) begin
      log_idx = 2'(k);
      #1;
`ifdef RUN_SEQUENCER_LOG_EN
      exp = (k < NUM_PROGS) ? exp_log[k] : 0;
`else
      exp = 0;
`endif
      check($sformatf("log_%0d", k), log_cycles, exp);
    end
    log_idx = 2'd0;
  endtask

  // Starts a run from IDLE and follows it to FINISH; called positioned 1 time unit after an edge.
  task automatic do_run(input bit hold_go);
    int prog = 0;
    int run_i = -1;
    int start_len = 0;
    int exp_c;
    bit exp_e;
    bit err_run = 1'b0;
    bit want_start = 1'b0;
    bit finished = 1'b0;
    int budget = NUM_PROGS * (TIMEOUT + START_CYCLES + 4) + 8;
    go = 1'b1;
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      @(posedge clk);
      #1;
      if (!hold_go) go = 1'b0;
      if (want_start) begin
        check("restart_latency", core_start, 1);
        want_start = 1'b0;
      end
      if (core_start) begin
        if (start_len == 0) check("prog_sel_start", prog_sel, prog);
        check("busy_start", busy, 1);
        start_len++;
        run_i = -1;
      end else if (cycles_valid) begin
        ref_capture(prog, exp_c, exp_e);
        err_run |= exp_e;
        check("cycles", cycles, exp_c);
        check("capture_index", run_i, exp_c);
        check("prog_sel_cap", prog_sel, prog);
        check("timeout_err_cap", timeout_err, err_run);
        exp_log[prog] = exp_c;
        prog++;
        want_start = (prog < NUM_PROGS);
      end else if (all_done) begin
        check("progs_done", prog, NUM_PROGS);
        check("finish_busy", busy, 0);
        check("finish_err", timeout_err, err_run);
        finished = 1'b1;
      end else if (busy) begin
        if (run_i < 0) begin
          check("start_len", start_len, START_CYCLES);
          start_len = 0;
        end
        run_i++;
        core_done = done_level(prog, run_i);
      end else begin
        check("unexpected_idle", busy, 1);
        finished = 1'b1;
      end
    end
    check("run_completed", finished, 1);
    if (hold_go) begin
      repeat (3) begin
        @(posedge clk);
        #1;
        check("go_held_finish", all_done, 1);
        check("go_held_no_start", core_start, 0);
      end
      go = 1'b0;
    end
    @(posedge clk);
    #1;
    check("back_idle_all_done", all_done, 0);
    check("back_idle_busy", busy, 0);
    check_log();
  endtask

  initial begin
    int waited;
    // Reset from a known high level so the asynchronous edge is seen.
    #2 reset = 1'b0;
    #1;
    check_quiet("reset");
    check("reset_prog_sel", prog_sel, 0);
    check("reset_cycles", cycles, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_quiet("idle");
    end
    for (int p = 0; p < NUM_PROGS; p++) exp_log[p] = 0;
    check_log();

    // Fixed 50-cycle latency on every program.
    for (int p = 0; p < NUM_PROGS; p++) set_wave(p, 0, 50);
    do_run(1'b0);

    // Sticky done carried into RUN, then short and single-cycle drops.
    set_wave(0, 0, 30);
    set_wave(1, 4, 20);
    set_wave(2, 3, 1);
    do_run(1'b0);

    // Middle program never finishes; the last one still runs.
    set_wave(0, 0, 15);
    set_wave(1, 0, NEVER);
    set_wave(2, 0, 40);
    do_run(1'b0);

    // Log latencies with go held high through FINISH.
    set_wave(0, 0, 10);
    set_wave(1, 0, 30);
    set_wave(2, 0, 70);
    do_run(1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < NUM_PROGS; p++) begin
        if ($urandom_range(0, 1) == 0) set_wave(p, 0, int'($urandom_range(1, 120)));
        else                           set_wave(p, int'($urandom_range(1, 6)), int'($urandom_range(1, 25)));
      end
      do_run(1'b0);
    end

    // Reset during RUN of program 1 after program 0 has timed out.
    set_wave(0, 0, NEVER);
    set_wave(1, 0, NEVER);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    waited = 0;
    while (!cycles_valid && waited < TIMEOUT + 50) begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      waited++;
    end
    check("midrun_first_capture", cycles_valid, 1);
    repeat (10) @(posedge clk);
    #1;
    check("pre_reset_err", timeout_err, 1);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_prog", prog_sel, 1);
    reset = 1'b0;
    #1;
    check_quiet("midrun_reset");
    check("midrun_prog_sel", prog_sel, 0);
    repeat (2) @(posedge clk);
    #1;
    check_quiet("held_reset");
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_quiet("after_reset");
    end

    for (int p = 0; p < NUM_PROGS; p++) set_wave(p, 0, 5 + 7 * p);
    do_run(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
